// File: rtl/ddr3_axi_tester_pkg.sv
// Shared types and constants for the DDR3 AXI traffic generator/checker.
//   state_e        - top-level sequencer states
//   AXI_BURST_INCR - AxBURST encoding for incrementing bursts
//   AXI_RESP_OKAY  - xRESP encoding for a successful transfer
//   LFSR_TAP*      - feedback taps of the 32-bit pattern generator
//   lfsr_next()    - one step of the pattern sequence
package ddr3_axi_tester_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StWrResp,
    StRdAddr,
    StRdData,
    StDone
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned LFSR_TAP0 = 31;
  localparam int unsigned LFSR_TAP1 = 21;
  localparam int unsigned LFSR_TAP2 = 1;
  localparam int unsigned LFSR_TAP3 = 0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    return {cur[30:0], cur[LFSR_TAP0] ^ cur[LFSR_TAP1] ^ cur[LFSR_TAP2] ^ cur[LFSR_TAP3]};
  endfunction

endpackage

// File: rtl/ddr3_axi_tester_lfsr.sv
// 32-bit Fibonacci LFSR producing the test pattern.
//   clk_i     - clock
//   rst_i     - synchronous active-high reset, loads SEED
//   load_i    - reload SEED (wins over advance_i)
//   advance_i - step to the next pattern value
//   value_o   - current pattern value
module ddr3_axi_tester_lfsr
  import ddr3_axi_tester_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2345
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        advance_i,
  output logic [31:0] value_o
);

  logic [31:0] value_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      value_q <= SEED;
    end else if (advance_i) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/ddr3_axi_tester.sv
// AXI4 master that writes an LFSR pattern over a memory region in INCR bursts, reads it
// back, and reports pass/fail, a saturating error count and the first failing address.
//   clk_i, rst_i             - clock, synchronous active-high reset
//   start_i                  - begin a run (honoured only when idle or done)
//   busy_o, done_o, pass_o   - run status; pass_o valid while done_o is high
//   error_count_o            - saturating count of failed beats/responses
//   first_err_addr_o         - byte address of the first error of the run
//   outport_aw*/w*/b*        - AXI write channels
//   outport_ar*/r*           - AXI read channels
module ddr3_axi_tester
  import ddr3_axi_tester_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned TEST_WORDS = 1024,
  parameter int unsigned BURST_LEN  = 16,
  parameter logic [3:0]  AXI_ID     = 4'h0,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2345
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] error_count_o,
  output logic [31:0] first_err_addr_o,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  input  logic        outport_awready_i,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  input  logic        outport_wready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  output logic        outport_bready_o,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_arready_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_rready_o
);

  localparam logic [7:0]  AxLen      = 8'(BURST_LEN - 1);
  localparam logic [15:0] LastBeat   = 16'(BURST_LEN - 1);
  localparam logic [31:0] LastBurst  = 32'(TEST_WORDS / BURST_LEN - 1);
  localparam logic [31:0] BurstBytes = 32'(BURST_LEN * 4);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [15:0] beat_q;
  logic [31:0] burst_q;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] first_err_q;
  logic        busy_q, done_q, pass_q;
  logic        awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;

  logic [31:0] lfsr;
  logic        lfsr_load, lfsr_advance;
  logic        err_event;
  logic [31:0] err_addr;
  logic        start_ok;
  logic        last_burst;

  assign start_ok   = ((state_q == StIdle) || (state_q == StDone)) && start_i;
  assign last_burst = (burst_q == LastBurst);

  // Reload at run start and again when switching from write to read phase.
  assign lfsr_load    = start_ok || ((state_q == StWrResp) && outport_bvalid_i && last_burst);
  assign lfsr_advance = ((state_q == StWrData) && outport_wready_i) ||
                        ((state_q == StRdData) && outport_rvalid_i);

  ddr3_axi_tester_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (lfsr_load),
    .advance_i (lfsr_advance),
    .value_o   (lfsr)
  );

  // At most one error per beat/response; the count saturates.
  always_comb begin
    err_event = 1'b0;
    err_addr  = addr_q;
    if ((state_q == StWrResp) && outport_bvalid_i) begin
      err_event = (outport_bresp_i != AXI_RESP_OKAY) || (outport_bid_i != AXI_ID);
    end else if ((state_q == StRdData) && outport_rvalid_i) begin
      err_event = (outport_rdata_i != lfsr) || (outport_rresp_i != AXI_RESP_OKAY) ||
                  (outport_rid_i != AXI_ID) || (outport_rlast_i && (beat_q != LastBeat));
      err_addr  = addr_q + {14'd0, beat_q, 2'b00};
    end
    err_cnt_d = err_cnt_q;
    if (err_event && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      beat_q      <= '0;
      burst_q     <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      if (err_event) begin
        err_cnt_q <= err_cnt_d;
        if (err_cnt_q == 16'd0) begin
          first_err_q <= err_addr;
        end
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q     <= StWrAddr;
            addr_q      <= BASE_ADDR;
            burst_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            awvalid_q   <= 1'b1;
          end
        end
        StWrAddr: begin
          if (outport_awready_i) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (LastBeat == 16'd0);
            beat_q    <= '0;
            state_q   <= StWrData;
          end
        end
        StWrData: begin
          if (outport_wready_i) begin
            beat_q <= beat_q + 16'd1;
            if (beat_q == LastBeat) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= StWrResp;
            end else begin
              wlast_q <= ((beat_q + 16'd1) == LastBeat);
            end
          end
        end
        StWrResp: begin
          if (outport_bvalid_i) begin
            bready_q <= 1'b0;
            if (last_burst) begin
              addr_q    <= BASE_ADDR;
              burst_q   <= '0;
              arvalid_q <= 1'b1;
              state_q   <= StRdAddr;
            end else begin
              addr_q    <= addr_q + BurstBytes;
              burst_q   <= burst_q + 32'd1;
              awvalid_q <= 1'b1;
              state_q   <= StWrAddr;
            end
          end
        end
        StRdAddr: begin
          if (outport_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= StRdData;
          end
        end
        StRdData: begin
          if (outport_rvalid_i) begin
            beat_q <= beat_q + 16'd1;
            // Only rlast closes a burst; surplus beats keep being checked.
            if (outport_rlast_i) begin
              rready_q <= 1'b0;
              if (last_burst) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (err_cnt_d == 16'd0);
                state_q <= StDone;
              end else begin
                burst_q   <= burst_q + 32'd1;
                addr_q    <= addr_q + BurstBytes;
                arvalid_q <= 1'b1;
                state_q   <= StRdAddr;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign error_count_o     = err_cnt_q;
  assign first_err_addr_o  = first_err_q;

  assign outport_awvalid_o = awvalid_q;
  assign outport_awaddr_o  = addr_q;
  assign outport_awid_o    = AXI_ID;
  assign outport_awlen_o   = AxLen;
  assign outport_awburst_o = AXI_BURST_INCR;

  assign outport_wvalid_o  = wvalid_q;
  assign outport_wdata_o   = lfsr;
  assign outport_wstrb_o   = 4'hF;
  assign outport_wlast_o   = wlast_q;

  assign outport_bready_o  = bready_q;

  assign outport_arvalid_o = arvalid_q;
  assign outport_araddr_o  = addr_q;
  assign outport_arid_o    = AXI_ID;
  assign outport_arlen_o   = AxLen;
  assign outport_arburst_o = AXI_BURST_INCR;

  assign outport_rready_o  = rready_q;

endmodule

// File: tb/tb_ddr3_axi_tester.sv
module tb_ddr3_axi_tester;

  localparam int unsigned BL = 4;
  localparam int unsigned TW = 16;
  localparam int unsigned NB = TW / BL;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SEED = 32'hACE1_2345;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [31:0] first_err;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, arid, wstrb, bid, rid;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;

  always #5 clk = ~clk;

  ddr3_axi_tester #(
    .BASE_ADDR  (BASE),
    .TEST_WORDS (TW),
    .BURST_LEN  (BL),
    .AXI_ID     (4'h0),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .busy_o            (busy),
    .done_o            (done),
    .pass_o            (pass),
    .error_count_o     (err_cnt),
    .first_err_addr_o  (first_err),
    .outport_awvalid_o (awvalid),
    .outport_awaddr_o  (awaddr),
    .outport_awid_o    (awid),
    .outport_awlen_o   (awlen),
    .outport_awburst_o (awburst),
    .outport_awready_i (awready),
    .outport_wvalid_o  (wvalid),
    .outport_wdata_o   (wdata),
    .outport_wstrb_o   (wstrb),
    .outport_wlast_o   (wlast),
    .outport_wready_i  (wready),
    .outport_bvalid_i  (bvalid),
    .outport_bresp_i   (bresp),
    .outport_bid_i     (bid),
    .outport_bready_o  (bready),
    .outport_arvalid_o (arvalid),
    .outport_araddr_o  (araddr),
    .outport_arid_o    (arid),
    .outport_arlen_o   (arlen),
    .outport_arburst_o (arburst),
    .outport_arready_i (arready),
    .outport_rvalid_i  (rvalid),
    .outport_rdata_i   (rdata),
    .outport_rresp_i   (rresp),
    .outport_rid_i     (rid),
    .outport_rlast_i   (rlast),
    .outport_rready_o  (rready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected pattern, straight from the shift/xor rule.
  logic [31:0] seq [0:TW-1];

  // Scenario knobs for the slave (-1 = fault disabled).
  bit cfg_stall   = 0;
  int cfg_flip    = -1;
  int cfg_bresp   = -1;
  int cfg_bid     = -1;
  int cfg_early   = -1;

  // Memory slave state.
  logic [31:0] mem [0:TW-1];
  logic [31:0] aw_addr [0:NB-1];
  logic [31:0] r_addr [0:NB-1];
  int aw_n, w_idx, b_owed, b_idx, ar_n, r_owed, r_burst, r_beat, r_idx;
  bit aw_stall, w_stall, ar_stall, b_hold, r_hold;
  logic [31:0] aw_stall_addr, w_stall_data, ar_stall_addr;
  logic        w_stall_last;

  task automatic slave_clear();
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
    bresp = 0; bid = 0; rresp = 0; rid = 0; rdata = 0;
    aw_n = 0; w_idx = 0; b_owed = 0; b_idx = 0; ar_n = 0; r_owed = 0;
    r_burst = 0; r_beat = 0; r_idx = 0;
    aw_stall = 0; w_stall = 0; ar_stall = 0; b_hold = 0; r_hold = 0;
  endtask

  function automatic bit rnd_ready();
    return cfg_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  // Runs at every falling edge: decides ready/valid for the next rising edge, so a
  // handshake is known here and recorded immediately.
  task automatic slave_step();
    bit hs;
    int word;
    if (rst) begin
      slave_clear();
      return;
    end
    if (aw_stall) begin
      chk("aw_hold_valid", 32'(awvalid), 1);
      chk("aw_hold_addr", awaddr, aw_stall_addr);
    end
    if (w_stall) begin
      chk("w_hold_valid", 32'(wvalid), 1);
      chk("w_hold_data", wdata, w_stall_data);
      chk("w_hold_last", 32'(wlast), 32'(w_stall_last));
    end
    if (ar_stall) begin
      chk("ar_hold_valid", 32'(arvalid), 1);
      chk("ar_hold_addr", araddr, ar_stall_addr);
    end
    // B before W so a response is only offered after its last beat was taken.
    if (!b_hold) begin
      if (b_owed > 0) begin
        bvalid = rnd_ready();
        bresp  = (b_idx == cfg_bresp) ? 2'b10 : 2'b00;
        bid    = (b_idx == cfg_bid) ? 4'h3 : 4'h0;
      end else begin
        bvalid = 0;
      end
    end
    hs = bvalid && bready;
    b_hold = bvalid && !hs;
    if (hs) begin
      b_owed--;
      b_idx++;
    end
    // AW
    awready = rnd_ready();
    hs = awvalid && awready;
    aw_stall = awvalid && !awready;
    aw_stall_addr = awaddr;
    if (hs) begin
      if (aw_n < NB) begin
        chk("awaddr", awaddr, BASE + 32'(aw_n * BL * 4));
        aw_addr[aw_n] = awaddr;
      end else begin
        chk("aw_count", 32'(aw_n), NB - 1);
      end
      chk("awlen", 32'(awlen), BL - 1);
      chk("awburst", 32'(awburst), 1);
      chk("awid", 32'(awid), 0);
      aw_n++;
    end
    // W
    wready = rnd_ready();
    hs = wvalid && wready;
    w_stall = wvalid && !wready;
    w_stall_data = wdata;
    w_stall_last = wlast;
    if (hs) begin
      chk("w_after_aw", 32'(w_idx / BL < aw_n), 1);
      if (w_idx < TW && w_idx / BL < aw_n) begin
        chk("wdata", wdata, seq[w_idx]);
        word = int'((aw_addr[w_idx / BL] - BASE) / 4) + w_idx % BL;
        if (word >= 0 && word < TW) mem[word] = wdata;
      end else begin
        chk("w_count", 32'(w_idx), TW - 1);
      end
      chk("wlast", 32'(wlast), 32'((w_idx % BL) == BL - 1));
      chk("wstrb", 32'(wstrb), 32'hF);
      if (wlast) b_owed++;
      w_idx++;
    end
    // R before AR so data never precedes its address handshake.
    if (!r_hold) begin
      if (r_owed > 0) begin
        rvalid = rnd_ready();
        word   = int'((r_addr[r_burst] - BASE) / 4) + r_beat;
        rdata  = (word >= 0 && word < TW) ? mem[word] : 32'h0;
        if (r_idx == cfg_flip) rdata = rdata ^ 32'h1;
        rlast  = (r_beat == BL - 1) || (r_burst == cfg_early && r_beat == 2);
        rresp  = 0;
        rid    = 0;
      end else begin
        rvalid = 0;
        rlast  = 0;
      end
    end
    hs = rvalid && rready;
    r_hold = rvalid && !hs;
    if (hs) begin
      r_idx++;
      r_beat++;
      if (rlast) begin
        r_beat = 0;
        r_burst++;
        r_owed--;
      end
    end
    // AR
    arready = rnd_ready();
    hs = arvalid && arready;
    ar_stall = arvalid && !arready;
    ar_stall_addr = araddr;
    if (hs) begin
      if (ar_n < NB) begin
        chk("araddr", araddr, BASE + 32'(ar_n * BL * 4));
        r_addr[ar_n] = araddr;
      end else begin
        chk("ar_count", 32'(ar_n), NB - 1);
      end
      chk("arlen", 32'(arlen), BL - 1);
      chk("arburst", 32'(arburst), 1);
      chk("arid", 32'(arid), 0);
      ar_n++;
      r_owed++;
    end
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      slave_step();
    end
  end

  typedef struct {
    bit          stall;
    int          flip;
    int          bresp_burst;
    int          bid_burst;
    int          early_burst;
    int          exp_err;
    logic [31:0] exp_addr;
    bit          exp_pass;
  } vec_t;

  vec_t vecs [0:5];

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    bit seen_done;
    string tag;
    tag = $sformatf("v%0d", id);
    cfg_stall = v.stall;
    cfg_flip  = v.flip;
    cfg_bresp = v.bresp_burst;
    cfg_bid   = v.bid_burst;
    cfg_early = v.early_burst;
    do_reset();
    pulse_start();
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    chk({tag, "_done_after_start"}, 32'(done), 0);
    // A start while busy must not restart the run (address checks would trip).
    repeat (10) @(negedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    seen_done = 0;
    for (int i = 0; i < 3000 && !seen_done; i++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk({tag, "_done_reached"}, 32'(seen_done), 1);
    chk({tag, "_busy_at_done"}, 32'(busy), 0);
    chk({tag, "_pass"}, 32'(pass), 32'(v.exp_pass));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(v.exp_err));
    chk({tag, "_first_err"}, first_err, v.exp_addr);
    chk({tag, "_aw_bursts"}, 32'(aw_n), NB);
    chk({tag, "_w_beats"}, 32'(w_idx), TW);
    chk({tag, "_ar_bursts"}, 32'(ar_n), NB);
    repeat (3) @(negedge clk);
    chk({tag, "_done_held"}, 32'(done), 1);
  endtask

  initial begin
    int fw;
    bit seen;
    seq[0] = SEED;
    for (int i = 1; i < TW; i++) begin
      seq[i] = {seq[i-1][30:0], seq[i-1][31] ^ seq[i-1][21] ^ seq[i-1][1] ^ seq[i-1][0]};
    end
    fw = int'($urandom_range(0, TW - 1));
    vecs[0] = '{0, -1, -1, -1, -1, 0, 32'h00, 1};
    vecs[1] = '{0, 5, -1, -1, -1, 1, 32'h14, 0};
    vecs[2] = '{1, -1, -1, -1, -1, 0, 32'h00, 1};
    vecs[3] = '{0, -1, 1, 2, -1, 2, 32'h10, 0};
    vecs[4] = '{0, -1, -1, -1, 3, 1, 32'h38, 0};
    vecs[5] = '{1, fw, -1, -1, -1, 1, BASE + 32'(fw * 4), 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_first_err", first_err, 0);
    chk("rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset in the middle of a write burst.
    cfg_stall = 0; cfg_flip = -1; cfg_bresp = -1; cfg_bid = -1; cfg_early = -1;
    do_reset();
    pulse_start();
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (wvalid && w_idx >= 2) seen = 1;
    end
    chk("mid_rst_reached_wdata", 32'(seen), 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rst_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    #1 rst = 0;
    run_vec(vecs[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
